// File: rtl/shreg256_seq_ctrl.sv
// Sequencer for the 256-bit load/left-shift register: word-serial operand load
// followed by a fixed left shift or a normalize-until-MSB-set pass.
module shreg256_seq_ctrl #(
  parameter int WORDS = 16,
  parameter int WW    = 16,
  parameter int CW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [CW-1:0] shamt,
  input  logic [WW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic          reg_msb,
  output logic          reg_we,
  output logic          reg_sel_ls,
  output logic [WW-1:0] reg_din,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] shcnt,
  output logic          zero
);

  localparam int WCW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0]  SH_MAX   = CW'(WORDS * WW);
  localparam logic [CW-1:0]  NORM_MAX = CW'(WORDS * WW - 1);
  localparam logic [WCW-1:0] WLAST    = WCW'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t         state, state_nxt;
  logic           mode_q, mode_nxt;
  logic [CW-1:0]  rem, rem_nxt;
  logic [CW-1:0]  shcnt_nxt;
  logic           zero_nxt;
  logic [WCW-1:0] wcnt, wcnt_nxt;
  logic           we_c, sel_c;
  logic [WW-1:0]  din_c;

  function automatic logic [CW-1:0] sat_shamt(input logic [CW-1:0] a);
    return (a > SH_MAX) ? SH_MAX : a;
  endfunction

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    rem_nxt   = rem;
    shcnt_nxt = shcnt;
    zero_nxt  = zero;
    wcnt_nxt  = wcnt;
    we_c      = 1'b0;
    sel_c     = 1'b0;
    din_c     = '0;
    din_ready = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          mode_nxt  = mode;
          rem_nxt   = sat_shamt(shamt);
          shcnt_nxt = '0;
          zero_nxt  = 1'b0;
          wcnt_nxt  = '0;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        din_ready = 1'b1;
        if (din_valid) begin
          we_c     = 1'b1;
          din_c    = din;
          wcnt_nxt = wcnt + WCW'(1);
          if (wcnt == WLAST) state_nxt = mode_q ? NORM : SHIFT;
        end
      end
      SHIFT: begin
        if (rem != '0) begin
          we_c      = 1'b1;
          sel_c     = 1'b1;
          rem_nxt   = rem - CW'(1);
          shcnt_nxt = shcnt + CW'(1);
        end else begin
          state_nxt = DONE;
        end
      end
      NORM: begin
        // The all-zero case stops after 255 shifts instead of spinning forever.
        if (reg_msb) begin
          state_nxt = DONE;
        end else if (shcnt != NORM_MAX) begin
          we_c      = 1'b1;
          sel_c     = 1'b1;
          shcnt_nxt = shcnt + CW'(1);
        end else begin
          zero_nxt  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register controls are suppressed during reset so an aborted op never writes.
  assign reg_we     = we_c & ~rst;
  assign reg_sel_ls = sel_c & ~rst;
  assign reg_din    = rst ? '0 : din_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      rem    <= '0;
      shcnt  <= '0;
      zero   <= 1'b0;
      wcnt   <= '0;
    end else begin
      state  <= state_nxt;
      mode_q <= mode_nxt;
      rem    <= rem_nxt;
      shcnt  <= shcnt_nxt;
      zero   <= zero_nxt;
      wcnt   <= wcnt_nxt;
    end
  end

endmodule

// File: tb/tb_shreg256_seq_ctrl.sv
// Bench for shreg256_seq_ctrl: drives directed operations against a timeline
// model of each op and a behavioural model of the 256-bit register.
module tb_shreg256_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, mode;
  logic [8:0]  shamt;
  logic [15:0] din;
  logic        din_valid, din_ready, reg_msb, reg_we, reg_sel_ls;
  logic [15:0] reg_din;
  logic        busy, done;
  logic [8:0]  shcnt;
  logic        zero;

  shreg256_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .shamt(shamt),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .reg_msb(reg_msb), .reg_we(reg_we), .reg_sel_ls(reg_sel_ls),
    .reg_din(reg_din), .busy(busy), .done(done), .shcnt(shcnt), .zero(zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // The register the sequencer controls: words enter at the top, LSW first.
  logic [255:0] regm = '0;
  always @(posedge clk)
    if (reg_we) regm <= reg_sel_ls ? {regm[254:0], 1'b0} : {reg_din, regm[255:16]};
  assign reg_msb = regm[255];

  // Expected timeline of the op in flight.
  bit           op_active = 1'b0;
  bit           stl = 1'b0, ez = 1'b0;
  int           t0 = 0, tl = 0, tdone = 0, nsh = 0;
  logic [255:0] opnd = '0, eres = '0;
  int           h_sh = 0;
  bit           h_z = 1'b0;
  int           seen_done = -1;
  int           checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit acc_at(input int c);
    return (c > t0) && (c <= tl) && (!stl || ((c - t0) % 2 == 1));
  endfunction

  function automatic logic [15:0] word_at(input int c);
    int idx;
    idx = stl ? (c - t0 - 1) / 2 : c - t0 - 1;
    return opnd[idx*16 +: 16];
  endfunction

  always @(negedge clk) begin
    int c;
    bit a, sh;
    c = cyc;
    if (done === 1'b1) seen_done = c;
    if (rst) begin
      chk("ctl_in_rst", 256'({reg_we, reg_sel_ls}), 256'(0));
    end else if (!op_active) begin
      chk("idle_ctl", 256'({busy, din_ready, reg_we, reg_sel_ls, done}), 256'(0));
      chk("idle_shcnt", 256'(shcnt), 256'(h_sh));
      chk("idle_zero", 256'(zero), 256'(h_z));
    end else begin
      a  = acc_at(c);
      sh = (c > tl) && (c <= tl + nsh);
      chk("ctl", 256'({busy, din_ready, reg_we, reg_sel_ls, done}),
          256'({c > t0, (c > t0) && (c <= tl), a || sh, sh, c == tdone}));
      if (a) chk("reg_din", 256'(reg_din), 256'(word_at(c)));
      if (c == tdone) begin
        chk("shcnt", 256'(shcnt), 256'(nsh));
        chk("zero", 256'(zero), 256'(ez));
        chk("register", regm, eres);
        op_active = 1'b0;
        h_sh = nsh;
        h_z  = ez;
      end
    end
  end

  task automatic run_op(input bit m, input logic [8:0] sa, input logic [255:0] op,
                        input bit st, input int abort_at, input bit ghost);
    int lz;
    @(posedge clk); #1;
    t0   = cyc;
    stl  = st;
    tl   = st ? t0 + 31 : t0 + 16;
    opnd = op;
    lz   = 256;
    for (int i = 255; i >= 0; i--) if (op[i]) begin lz = 255 - i; break; end
    if (m) begin
      nsh = (lz == 256) ? 255 : lz;
      ez  = (lz == 256);
    end else begin
      nsh = (sa > 9'd256) ? 256 : int'(sa);
      ez  = 1'b0;
    end
    eres = op << nsh;
    tdone = tl + 2 + nsh;
    seen_done = -1;
    start = 1'b1; mode = m; shamt = sa;
    op_active = 1'b1;
    forever begin
      @(posedge clk); #1;
      start = 1'b0; mode = ~m; shamt = 9'd3;
      din_valid = acc_at(cyc);
      din = din_valid ? word_at(cyc) : 16'hDEAD;
      if (abort_at > 0 && cyc == t0 + abort_at) begin
        rst = 1'b1; din_valid = 1'b1; din = 16'hBEEF;
        op_active = 1'b0; h_sh = 0; h_z = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; din_valid = 1'b0;
        @(negedge clk);
        chk("abort_state", 256'({busy, reg_we, shcnt}), 256'(0));
        return;
      end
      if (ghost && (cyc == t0 + 5 || cyc == tdone)) start = 1'b1;
      if (cyc >= tdone) break;
    end
    @(posedge clk); #1;
    start = 1'b0; din_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; shamt = '0; din = '0; din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", 256'({busy, done, din_ready, reg_we, reg_sel_ls, shcnt, zero, reg_din}), 256'(0));

    run_op(1'b0, 9'd5, 256'h1, 1'b0, 0, 1'b1);
    chk("t1_done_off", 256'(seen_done - t0), 256'(23));
    chk("t1_shcnt", 256'(shcnt), 256'(5));
    chk("t1_word0", 256'(regm[15:0]), 256'(16'h0020));

    run_op(1'b1, 9'd0, 256'h0100 << 240, 1'b0, 0, 1'b0);
    chk("t2_done_off", 256'(seen_done - t0), 256'(25));
    chk("t2_shcnt_zero", 256'({shcnt, zero, reg_msb}), 256'({9'd7, 1'b0, 1'b1}));

    run_op(1'b1, 9'd0, 256'h0, 1'b0, 0, 1'b0);
    chk("t3_done_off", 256'(seen_done - t0), 256'(273));
    chk("t3_shcnt_zero", 256'({shcnt, zero}), 256'({9'd255, 1'b1}));

    run_op(1'b0, 9'd0, 256'hABCD, 1'b0, 0, 1'b0);
    chk("t4_done_off", 256'(seen_done - t0), 256'(18));
    chk("t4_word0", 256'(regm[15:0]), 256'(16'hABCD));

    run_op(1'b0, 9'd300, {8{32'h9E37_79B9}}, 1'b0, 0, 1'b0);
    chk("t5_done_off", 256'(seen_done - t0), 256'(274));
    chk("t5_shcnt", 256'(shcnt), 256'(256));

    run_op(1'b0, 9'd5, 256'h1, 1'b1, 0, 1'b0);
    chk("t6_done_off", 256'(seen_done - t0), 256'(38));
    chk("t6_word0", 256'(regm[15:0]), 256'(16'h0020));

    run_op(1'b0, 9'd5, 256'h1234, 1'b0, 8, 1'b0);
    run_op(1'b0, 9'd3, 256'h1234, 1'b0, 0, 1'b0);
    chk("t8_word0", 256'(regm[15:0]), 256'(16'h91A0));

    run_op(1'b0, 9'd20, 256'h5, 1'b0, 22, 1'b0);
    run_op(1'b1, 9'd0, 256'h1 << 200, 1'b0, 0, 1'b0);
    chk("t10_done_off", 256'(seen_done - t0), 256'(73));
    chk("t10_shcnt", 256'(shcnt), 256'(55));

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
